// File: rtl/parport_pkg.sv
// Shared types and default timing constants for the parallel-port receiver.
package parport_pkg;

    // Handshake FSM states seen from the peripheral side.
    typedef enum logic [1:0] {
        PP_IDLE    = 2'd0,
        PP_ACK     = 2'd1,
        PP_WAIT_HI = 2'd2
    } pp_state_e;

    // 5 us acknowledge pulse at 32 MHz.
    localparam int PP_ACK_CYCLES_DEF = 160;
    // Consecutive synchronized samples before a strobe edge is believed.
    localparam int PP_FILTER_DEF     = 3;

endpackage

// File: rtl/parport_fifo.sv
// 8-bit first-word-fall-through receive FIFO. Push and pop in the same
// cycle are both honoured, even when full; pointers wrap modulo DEPTH.
module parport_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk32,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic          full_next_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o     = (level_q == '0);
    assign full_o      = (level_q == LW'(DEPTH));
    assign do_pop      = pop_i && !empty_o;
    assign do_push     = push_i && (!full_o || do_pop);
    assign full_next_o = (level_d == LW'(DEPTH));
    assign level_o     = level_q;
    // Head byte is shown directly; forced to zero while empty so the
    // output is well defined out of reset.
    assign rdata_o     = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Storage write.
    // NOTE: the data array is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk32) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/parport_rx.sv
// Centronics-style parallel-port receiver (peripheral end): synchronizes and
// filters the host strobe, captures bytes into a FIFO and drives BUSY/ACK.
module parport_rx
    import parport_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    parameter  int ACK_CYCLES = PP_ACK_CYCLES_DEF,
    parameter  int FILTER     = PP_FILTER_DEF,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk32,
    input  logic          reset_n,
    input  logic          pp_strobe_n,
    input  logic [7:0]    pp_data,
    output logic          pp_busy,
    output logic          pp_ack_n,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic [LW-1:0] rx_level,
    output logic          overrun,
    input  logic          overrun_clr
);

    localparam int FW  = $clog2(FILTER + 1);
    localparam int AKW = $clog2(ACK_CYCLES + 1);

    logic           strobe_s1_q, strobe_s2_q;
    logic [7:0]     data_s1_q, data_s2_q;
    logic           stb_f_q;
    logic [FW-1:0]  flt_cnt_q;
    logic           fall_q;
    pp_state_e      state_q, state_d;
    logic [AKW-1:0] ack_cnt_q, ack_cnt_d;
    logic           busy_q, ack_n_q, overrun_q;
    logic           push, overrun_set;
    logic           fifo_full, fifo_full_next, fifo_empty;

    // Two-flop synchronizers for the asynchronous host pins.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            strobe_s1_q <= 1'b1;
            strobe_s2_q <= 1'b1;
            data_s1_q   <= 8'h00;
            data_s2_q   <= 8'h00;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            strobe_s1_q <= pp_strobe_n;
            strobe_s2_q <= strobe_s1_q;
            data_s1_q   <= pp_data;
            data_s2_q   <= data_s1_q;
        end
    end

    // Glitch filter: accept a new strobe level after FILTER consecutive
    // differing samples; fall_q pulses on the accepted 1->0 change.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            stb_f_q   <= 1'b1;
            flt_cnt_q <= '0;
            fall_q    <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (strobe_s2_q != stb_f_q) begin
                if (flt_cnt_q == FW'(FILTER - 1)) begin
                    stb_f_q   <= strobe_s2_q;
                    flt_cnt_q <= '0;
                    fall_q    <= !strobe_s2_q;
                end else begin
                    flt_cnt_q <= flt_cnt_q + FW'(1);
                end
            end else begin
                flt_cnt_q <= '0;
            end
        end
    end

    // Handshake next-state logic: capture on fall, time the ACK pulse,
    // then hold off until the host releases the strobe.
    always_comb begin
        state_d     = state_q;
        ack_cnt_d   = ack_cnt_q;
        push        = 1'b0;
        overrun_set = 1'b0;
        unique case (state_q)
            PP_IDLE: begin
                if (fall_q) begin
                    ack_cnt_d = '0;
                    state_d   = PP_ACK;
                    if (fifo_full) overrun_set = 1'b1;
                    else           push        = 1'b1;
                end
            end
            PP_ACK: begin
                if (ack_cnt_q == AKW'(ACK_CYCLES - 1)) state_d = PP_WAIT_HI;
                else                                  ack_cnt_d = ack_cnt_q + AKW'(1);
            end
            PP_WAIT_HI: begin
                if (stb_f_q) state_d = PP_IDLE;
            end
            default: state_d = PP_IDLE;
        endcase
    end

    // FSM state, registered BUSY/ACK and the sticky overrun flag.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PP_IDLE;
            ack_cnt_q <= '0;
            busy_q    <= 1'b0;
            ack_n_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_cnt_q <= ack_cnt_d;
            busy_q    <= (state_d != PP_IDLE) || fifo_full_next;
            ack_n_q   <= (state_d != PP_ACK);
            if (overrun_set)      overrun_q <= 1'b1;
            else if (overrun_clr) overrun_q <= 1'b0;
        end
    end

    parport_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk32       (clk32),
        .reset_n     (reset_n),
        .push_i      (push),
        .wdata_i     (data_s2_q),
        .pop_i       (rx_ready),
        .rdata_o     (rx_data),
        .full_o      (fifo_full),
        .full_next_o (fifo_full_next),
        .empty_o     (fifo_empty),
        .level_o     (rx_level)
    );

    assign rx_valid = !fifo_empty;
    assign pp_busy  = busy_q;
    assign pp_ack_n = ack_n_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_parport_rx.sv
// Self-checking bench for parport_rx: directed handshake scenarios plus
// randomized transfers checked against a byte-queue reference model.
module tb_parport_rx;

    localparam int DEPTH = 16;
    localparam int ACKC  = 160;
    localparam int FILT  = 3;
    localparam int LW    = $clog2(DEPTH) + 1;
    // Pin fall to the edge that writes the byte and raises BUSY.
    localparam int CAP   = 3 + FILT;

    logic          clk32       = 1'b0;
    logic          reset_n     = 1'b1;
    logic          pp_strobe_n = 1'b1;
    logic [7:0]    pp_data     = 8'h00;
    logic          rx_ready    = 1'b0;
    logic          overrun_clr = 1'b0;
    logic          pp_busy, pp_ack_n, rx_valid, overrun;
    logic [7:0]    rx_data;
    logic [LW-1:0] rx_level;

    parport_rx #(.FIFO_DEPTH(DEPTH), .ACK_CYCLES(ACKC), .FILTER(FILT)) dut (
        .clk32       (clk32),
        .reset_n     (reset_n),
        .pp_strobe_n (pp_strobe_n),
        .pp_data     (pp_data),
        .pp_busy     (pp_busy),
        .pp_ack_n    (pp_ack_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_level    (rx_level),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk32 = ~clk32;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  model_q[$];
    bit          ovr_m     = 1'b0;
    bit          push_now  = 1'b0;
    logic [7:0]  push_byte = 8'h00;
    int          rdy_mode  = 0;   // 0: never ready, 1: always ready, 2: random
    int          max_level = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply consumer handshake, update the reference model
    // with this edge's pop/push, then compare the FIFO-facing outputs.
    task automatic step();
        bit full_pre;
        rx_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        full_pre = (model_q.size() == DEPTH);
        if (rx_ready && model_q.size() != 0) begin
            check("rx_data_pop", rx_data, model_q[0]);
            void'(model_q.pop_front());
        end
        if (push_now && !full_pre) model_q.push_back(push_byte);
        if (push_now && full_pre)  ovr_m = 1'b1;
        else if (overrun_clr)      ovr_m = 1'b0;
        @(posedge clk32);
        #1;
        push_now = 1'b0;
        if (int'(rx_level) > max_level) max_level = int'(rx_level);
        check("rx_level", rx_level, model_q.size());
        check("rx_valid", rx_valid, model_q.size() != 0);
        check("overrun", overrun, ovr_m);
    endtask

    // Host transfer: data setup, strobe low for 'low' cycles, then release and
    // idle long enough for the ACK pulse and WAIT_HI exit to complete.
    task automatic send_byte(input logic [7:0] b, input int low, input bit clr_at_push,
                             output int rise, output int ack_lo, output logic busy_rel);
        int tail;
        rise   = -1;
        ack_lo = 0;
        pp_data = b;
        repeat (CAP) step();
        pp_strobe_n = 1'b0;
        for (int i = 1; i <= low; i++) begin
            if (i == CAP) begin
                push_now    = 1'b1;
                push_byte   = b;
                overrun_clr = clr_at_push;
            end
            step();
            overrun_clr = 1'b0;
            if (pp_busy && rise < 0) rise = i;
            if (!pp_ack_n) ack_lo++;
        end
        busy_rel    = pp_busy;
        pp_strobe_n = 1'b1;
        tail = ((ACKC + 8 - low) > 0 ? (ACKC + 8 - low) : 0) + 8;
        for (int i = 0; i < tail; i++) begin
            step();
            if (!pp_ack_n) ack_lo++;
        end
    endtask

    task automatic glitch(input int g);
        pp_strobe_n = 1'b0;
        repeat (g) step();
        pp_strobe_n = 1'b1;
        repeat (8) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rise, ack_lo, w;
        logic busy_rel;
        logic busy_seen;

        // Reset values
        #2 reset_n = 1'b0;
        #3;
        check("rst_busy",    pp_busy,  1'b0);
        check("rst_ack_n",   pp_ack_n, 1'b1);
        check("rst_valid",   rx_valid, 1'b0);
        check("rst_data",    rx_data,  8'h00);
        check("rst_level",   rx_level, 0);
        check("rst_overrun", overrun,  1'b0);
        @(posedge clk32);
        #1 reset_n = 1'b1;
        repeat (4) step();

        // Single byte 0xA5, strobe low 1 us
        send_byte(8'hA5, 32, 1'b0, rise, ack_lo, busy_rel);
        check("t1_busy_rise", rise, CAP);
        check("t1_ack_width", ack_lo, ACKC);
        check("t1_data",      rx_data, 8'hA5);
        check("t1_valid",     rx_valid, 1'b1);
        check("t1_level",     rx_level, 1);
        check("t1_busy_end",  pp_busy, 1'b0);
        rdy_mode = 1; repeat (2) step(); rdy_mode = 0;

        // Two-cycle glitch is rejected
        busy_seen = 1'b0;
        pp_strobe_n = 1'b0;
        repeat (2) step();
        pp_strobe_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            busy_seen |= pp_busy;
        end
        check("t2_busy", busy_seen, 1'b0);
        check("t2_level", rx_level, 0);

        // Fill the FIFO, then overflow with clear in the set cycle
        for (int b = 0; b < DEPTH; b++) send_byte(8'(b), 32, 1'b0, rise, ack_lo, busy_rel);
        check("t3_full_busy",  pp_busy, 1'b1);
        check("t3_full_level", rx_level, DEPTH);
        send_byte(8'hEE, 32, 1'b1, rise, ack_lo, busy_rel);
        check("t3_overrun",   overrun, 1'b1);
        check("t3_ovr_level", rx_level, DEPTH);
        check("t3_ovr_busy",  pp_busy, 1'b1);
        rdy_mode = 1; step(); rdy_mode = 0;
        check("t3_pop_busy", pp_busy, 1'b0);
        check("t3_pop_data", rx_data, 8'h01);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        check("t3_ovr_clr", overrun, 1'b0);
        rdy_mode = 1; repeat (20) step(); rdy_mode = 0;

        // Strobe held low for 1000 cycles: one capture, BUSY held
        send_byte(8'h5A, 1000, 1'b0, rise, ack_lo, busy_rel);
        check("t4_busy_held", busy_rel, 1'b1);
        check("t4_level",     rx_level, 1);
        check("t4_data",      rx_data, 8'h5A);
        check("t4_busy_end",  pp_busy, 1'b0);
        rdy_mode = 1; repeat (2) step();

        // Back-to-back bytes with a always-ready consumer
        max_level = 0;
        send_byte(8'h11, 32, 1'b0, rise, ack_lo, busy_rel);
        send_byte(8'h22, 32, 1'b0, rise, ack_lo, busy_rel);
        send_byte(8'h33, 32, 1'b0, rise, ack_lo, busy_rel);
        check("t5_max_level", max_level, 1);
        rdy_mode = 0;

        // Reset in the middle of the ACK pulse
        pp_data = 8'h77;
        repeat (CAP) step();
        pp_strobe_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (i == CAP) begin push_now = 1'b1; push_byte = 8'h77; end
            step();
        end
        check("t6_in_ack", pp_ack_n, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_ack_n", pp_ack_n, 1'b1);
        check("t6_rst_busy",  pp_busy,  1'b0);
        check("t6_rst_valid", rx_valid, 1'b0);
        model_q.delete();
        ovr_m = 1'b0;
        pp_strobe_n = 1'b1;
        @(posedge clk32);
        #1 reset_n = 1'b1;
        repeat (4) step();
        send_byte(8'h3C, 32, 1'b0, rise, ack_lo, busy_rel);
        check("t6_rise", rise, CAP);
        check("t6_data", rx_data, 8'h3C);
        check("t6_level", rx_level, 1);

        // Randomized transfers with a random consumer and occasional glitches
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, FILT - 1));
            send_byte(8'($urandom_range(0, 255)), $urandom_range(CAP, 40), 1'b0, rise, ack_lo, busy_rel);
            check("rand_rise", rise, CAP);
            check("rand_ack_width", ack_lo, ACKC);
            w = 0;
            while (pp_busy && w < 2000) begin
                step();
                w++;
            end
            check("rand_busy_drain", pp_busy, 1'b0);
        end
        rdy_mode = 1;
        repeat (DEPTH + 4) step();
        check("final_level", rx_level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
